// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if : product-in / block-sum-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface product_accumulator_if #(
  parameter int PRODUCT_WIDTH = 4,
  parameter int ACC_WIDTH     = 8
);
  logic                     Clear_In;
  logic [PRODUCT_WIDTH-1:0] Product_In;
  logic                     Product_Valid_In;
  logic                     Product_Ready_Out;
  logic [ACC_WIDTH-1:0]     Sum_Out;
  logic                     Sum_Valid_Out;
  logic                     Sum_Ready_In;
  logic                     Sum_Saturated_Out;
  logic [7:0]               Count_Out;

  modport slave (
    input  Clear_In, Product_In, Product_Valid_In, Sum_Ready_In,
    output Product_Ready_Out, Sum_Out, Sum_Valid_Out, Sum_Saturated_Out, Count_Out
  );

  modport master (
    output Clear_In, Product_In, Product_Valid_In, Sum_Ready_In,
    input  Product_Ready_Out, Sum_Out, Sum_Valid_Out, Sum_Saturated_Out, Count_Out
  );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator : saturating sum of each block of COUNT products
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module product_accumulator #(
  parameter int PRODUCT_WIDTH = 4,
  parameter int COUNT         = 4,
  parameter int ACC_WIDTH     = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  product_accumulator_if.slave  bus
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam int         SUM_W    = ((ACC_WIDTH > PRODUCT_WIDTH) ? ACC_WIDTH : PRODUCT_WIDTH) + 1;
  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           count_q, count_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic                 sum_sat_q, sum_sat_d;

  logic [SUM_W-1:0]     w_sum_ext;
  logic                 w_overflow;
  logic [ACC_WIDTH-1:0] w_sum_sat;

  // Wide enough that neither operand is truncated before the overflow test
  assign w_sum_ext  = SUM_W'(acc_q) + SUM_W'(bus.Product_In);
  assign w_overflow = w_sum_ext > SUM_W'({ACC_WIDTH{1'b1}});
  assign w_sum_sat  = w_overflow ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    sum_sat_d   = sum_sat_q;

    if (bus.Clear_In) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      count_d     = '0;
      sat_d       = 1'b0;
      sum_valid_d = 1'b0;
      sum_sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.Product_Valid_In) begin
            if (count_q == LAST_IDX) begin
              sum_d       = w_sum_sat;
              sum_sat_d   = sat_q | w_overflow;
              sum_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
              sat_d       = 1'b0;
              state_d     = ST_HOLD;
            end else begin
              acc_d   = w_sum_sat;
              count_d = count_q + 8'd1;
              sat_d   = sat_q | w_overflow;
            end
          end
        end
        ST_HOLD: begin
          // Sum_Out deliberately keeps its value after the handshake
          if (sum_valid_q && bus.Sum_Ready_In) begin
            sum_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_sat_q   <= sum_sat_d;
    end
  end

  assign bus.Product_Ready_Out = (state_q == ST_ACCUM);
  assign bus.Sum_Out           = sum_q;
  assign bus.Sum_Valid_Out     = sum_valid_q;
  assign bus.Sum_Saturated_Out = sum_sat_q;
  assign bus.Count_Out         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator : scoreboard bench, 8-bit and 5-bit accumulators in lockstep
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_product_accumulator;

  localparam int COUNT = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  product_accumulator_if #(.PRODUCT_WIDTH(4), .ACC_WIDTH(8)) bus  ();
  product_accumulator_if #(.PRODUCT_WIDTH(4), .ACC_WIDTH(5)) bus5 ();

  assign bus5.Clear_In         = bus.Clear_In;
  assign bus5.Product_In       = bus.Product_In;
  assign bus5.Product_Valid_In = bus.Product_Valid_In;
  assign bus5.Sum_Ready_In     = bus.Sum_Ready_In;

  product_accumulator #(.PRODUCT_WIDTH(4), .COUNT(COUNT), .ACC_WIDTH(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
  product_accumulator #(.PRODUCT_WIDTH(4), .COUNT(COUNT), .ACC_WIDTH(5)) dut5 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus5.slave));

  typedef struct {
    int s8; int sat8; int s5; int sat5;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_acc8, m_acc5, m_sat8, m_sat5, m_cnt;
  logic rand_ready = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc8 = 0; m_acc5 = 0; m_sat8 = 0; m_sat5 = 0; m_cnt = 0;
  endtask

  task automatic sat_add(inout int acc, input int p, input int maxv, inout int flag, output int ovf);
    acc = acc + p;
    ovf = 0;
    if (acc > maxv) begin
      acc = maxv;
      ovf = 1;
    end
    flag = flag | ovf;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Present one product, wait for acceptance, then advance the model
  task automatic send(input logic [3:0] p);
    int   n;
    int   o8, o5;
    logic ok;
    exp_t e;
    bus.Product_In       = p;
    bus.Product_Valid_In = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge Clk);
      ok = bus.Product_Ready_Out && !bus.Clear_In;
      @(posedge Clk);
      n++;
    end
    #1;
    bus.Product_Valid_In = 1'b0;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    sat_add(m_acc8, int'(p), 255, m_sat8, o8);
    sat_add(m_acc5, int'(p), 31,  m_sat5, o5);
    m_cnt++;
    if (m_cnt == COUNT) begin
      e.s8 = m_acc8; e.sat8 = m_sat8; e.s5 = m_acc5; e.sat5 = m_sat5;
      sb.push_back(e);
      model_clear();
      chk("sum_valid_latency", int'(bus.Sum_Valid_Out), 1);
    end
    chk("count_out", int'(bus.Count_Out), m_cnt);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && bus.Sum_Valid_Out && bus.Sum_Ready_In) begin
      if (sb.size() == 0) begin
        chk("unexpected_sum", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sum8",       int'(bus.Sum_Out),            e.s8);
        chk("sat8",       int'(bus.Sum_Saturated_Out),  e.sat8);
        chk("sum5",       int'(bus5.Sum_Out),           e.s5);
        chk("sat5",       int'(bus5.Sum_Saturated_Out), e.sat5);
        chk("sum5_valid", int'(bus5.Sum_Valid_Out),     1);
      end
    end
  end

  always @(posedge Clk) begin
    if (rand_ready) begin
      #1;
      if (rand_ready) bus.Sum_Ready_In = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sum8"},   int'(bus.Sum_Out),            0);
    chk({tag, "_valid8"}, int'(bus.Sum_Valid_Out),      0);
    chk({tag, "_sat8"},   int'(bus.Sum_Saturated_Out),  0);
    chk({tag, "_count"},  int'(bus.Count_Out),          0);
    chk({tag, "_ready"},  int'(bus.Product_Ready_Out),  1);
    chk({tag, "_sum5"},   int'(bus5.Sum_Out),           0);
    chk({tag, "_valid5"}, int'(bus5.Sum_Valid_Out),     0);
  endtask

  initial begin
    int t;
    bus.Clear_In         = 1'b0;
    bus.Product_In       = '0;
    bus.Product_Valid_In = 1'b0;
    bus.Sum_Ready_In     = 1'b1;
    model_clear();

    idle(2);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    idle(1);

    // Back-to-back block: 9+6+4+1 = 20 (5-bit: 20)
    send(4'd9); send(4'd6); send(4'd4); send(4'd1);
    idle(2);

    // Held output under back-pressure
    bus.Sum_Ready_In = 1'b0;
    send(4'd3); send(4'd3); send(4'd3); send(4'd3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum",   int'(bus.Sum_Out),           12);
      chk("hold_valid", int'(bus.Sum_Valid_Out),     1);
      chk("hold_ready", int'(bus.Product_Ready_Out), 0);
      idle(1);
    end
    bus.Sum_Ready_In = 1'b1;
    idle(1);
    chk("ready_after_hs", int'(bus.Product_Ready_Out), 1);
    chk("sum_kept_after_hs", int'(bus.Sum_Out), 12);

    // Saturation on the 5-bit instance, then a clean block
    send(4'd9); send(4'd9); send(4'd9); send(4'd9);
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    idle(2);

    // Clear drops the partial block and the coincident product
    send(4'd2); send(4'd5);
    bus.Clear_In = 1'b1; bus.Product_In = 4'd7; bus.Product_Valid_In = 1'b1;
    idle(1);
    bus.Clear_In = 1'b0; bus.Product_Valid_In = 1'b0;
    model_clear();
    chk("clear_count", int'(bus.Count_Out), 0);
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    idle(2);

    // Asynchronous reset mid-block, away from any clock edge
    send(4'd5); send(4'd6);
    #1 Reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    #1 Reset_n = 1'b1;
    model_clear();
    idle(1);

    // Asynchronous reset while holding a result
    bus.Sum_Ready_In = 1'b0;
    send(4'd7); send(4'd7); send(4'd7); send(4'd7);
    idle(1);
    #1 Reset_n = 1'b0;
    #1 check_reset_outputs("rst_hold");
    chk("rst_hold_sat5", int'(bus5.Sum_Saturated_Out), 0);
    #1 Reset_n = 1'b1;
    sb.delete();
    model_clear();
    bus.Sum_Ready_In = 1'b1;
    idle(1);
    send(4'd4); send(4'd4); send(4'd4); send(4'd4);
    idle(2);

    // Random gaps and random downstream back-pressure
    rand_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < COUNT; k++) begin
        idle($urandom_range(0, 3));
        send(4'($urandom_range(0, 15)));
      end
    end
    rand_ready = 1'b0;
    idle(1);
    bus.Sum_Ready_In = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      idle(1);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
